fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for the dual-clock asynchronous FIFO. Lives entirely in the read clock domain and pops words through the FIFO's `rinc`/`rdata`/`rempty` port. It re-presents them as a registered valid/ready stream through a 2-entry buffer, so downstream back-pressure never has a combinational path into `rinc`. It sustains one word per `rclk` and preserves FIFO order exactly.

## Interface
- `DSIZE`, default 8: data width; matches the FIFO's `DSIZE`.
- `CNT_W`, default 16: width of the statistics counters. Only present with `FIFO_RD_STATS_EN`.

Ports:
- `rclk`  in  1  read-domain clock. The only clock.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `rempty`  in  1  FIFO empty flag. Registered in the FIFO.
- `rdata`  in  DSIZE  FIFO head word. Valid whenever `rempty`=0 (fall-through).
- `rinc`  out  1  pop strobe to the FIFO.
- `enable`  in  1  0 = stop issuing new pops. Buffered words still drain.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DSIZE  output word. Registered.
- `m_ready`  in  1  downstream accept.
- `occupancy`  out  2  words held in the buffer: 0, 1 or 2.
- `clr_stats`  in  1  synchronous clear of the counters. Macro only.
- `word_cnt`  out  CNT_W  words delivered. Macro only.
- `stall_cnt`  out  CNT_W  back-pressure cycles. Macro only.

## Operation
- Pop rule: `rinc` = `rrst_n` & `enable` & ~`rempty` & (occupancy != 2).
  - `rinc` depends on registered state plus `rempty`/`enable` only. It never depends on `m_ready`.
- Push: when `rinc`=1, `rdata` is written into the buffer at the rising edge of `rclk`.
- Accept: an accept is `m_valid` & `m_ready`. It retires the head entry; the skid entry, if present, moves to the head.
- Buffer state machine (`occupancy` is the state encoding):
  - EMPTY: push → ONE. No other transitions.
  - ONE:
    - push and accept → ONE (head replaced by the new word);
    - push only → TWO (new word goes to the skid entry);
    - accept only → EMPTY;
    - neither → ONE.
  - TWO: no push is possible.
    - accept → ONE (skid entry becomes head);
    - no accept → TWO.
- `m_valid` = (state != EMPTY). `m_data` = head entry.
- While `m_valid`=1 and `m_ready`=0, `m_data` is held stable.
- `enable` deasserted: pops stop the same cycle; held words continue to drain normally.
- `rempty` rising mid-stream: pops stop that cycle. No bubble is inserted into data already buffered.
- Words are never dropped or duplicated. The output order equals the FIFO pop order.

## Timing
- Reset (asynchronous assert, release synchronous to `rclk`):
  - `m_valid`=0, `m_data`=0, `occupancy`=0, `rinc`=0;
  - `word_cnt`=0, `stall_cnt`=0.
- Reset during operation discards both buffered words. The FIFO read side is reset by the same `rrst_n`.
- Latency:
  - `rempty` falls in cycle N with `enable`=1 and the buffer empty: `rinc`=1 in cycle N.
  - `m_valid`=1 with that word in cycle N+1.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word per cycle. `occupancy` stays at 1.
- Back-pressure: `m_ready`=0 with occupancy 1 and a pop in progress → occupancy 2 next cycle, and `rinc`=0 from then on.
- After the first accept, pops resume in the following cycle.

## Configuration
- `FIFO_RD_STATS_EN` defined: `clr_stats`, `word_cnt` and `stall_cnt` ports exist.
  - `word_cnt` increments on each accept. It saturates at all-ones.
  - `stall_cnt` increments on each cycle with `m_valid` & ~`m_ready`. It saturates at all-ones.
  - `clr_stats` zeroes both counters next cycle and has priority over an increment in the same cycle.
- Not defined: those ports and counters are absent. Datapath behaviour is identical.

## Structure
- Package `fifo_rd_pkg`:
  - buffer-state constants: EMPTY=2'd0, ONE=2'd1, TWO=2'd2;
  - default `DSIZE`/`CNT_W` constants shared with the FIFO bench.
- Sub-module `sat_counter` (width parameter; `inc`, `clr` inputs; saturating): instantiated twice under `FIFO_RD_STATS_EN`.

## Test plan
- Reset: assert `rrst_n`=0 for 4 cycles with `rempty`=0 → `rinc`=0, `m_valid`=0, `m_data`=0, `occupancy`=0 throughout.
- Streaming: FIFO preloaded with 0x01..0x0A, `m_ready`=1 → `m_data` = 0x01..0x0A on 10 consecutive cycles. First word appears 1 cycle after `rempty` falls. `rinc` is high for exactly 10 cycles.
- Back-pressure: stream 0x10..0x1F, drop `m_ready` for 5 cycles mid-stream.
  - `occupancy` reaches 2 and `rinc`=0 during the stall.
  - `m_data` stays stable while stalled.
  - All 16 words arrive in order with no loss.
- Enable gating: `enable`=0 while `occupancy`=2 → both held words drain, then `m_valid`=0. No pops occur until `enable` returns to 1.
- Empty boundary: FIFO holds one word 0xAB, `m_ready`=1 → one `rinc` pulse, `m_valid` for one cycle with 0xAB. No pop is issued while `rempty`=1.
- Stats (macro on, `CNT_W`=4): 20 accepts → `word_cnt`=15 (saturated). 3 stall cycles → `stall_cnt`=3. Assert `clr_stats` during an accept → both counters read 0 next cycle.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side drain engine: buffer-state encodings
// and default widths shared with the FIFO bench.
package fifo_rd_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Buffer state doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Registered valid/ready output stream of fifo_rd_stream.
interface fifo_rd_stream_if #(
    parameter int DSIZE = fifo_rd_pkg::DSIZE_DEF
);

    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_stream_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the async FIFO into a 2-entry registered skid buffer.
// Optional statistics counters are built when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
`ifdef FIFO_RD_STATS_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rempty,
    input  logic [DSIZE-1:0]  rdata,
    output logic              rinc,
    input  logic              enable,
    fifo_rd_stream_if.master  m,
    output logic [1:0]        occupancy
`ifdef FIFO_RD_STATS_EN
    ,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic [1:0]       state;
    logic [DSIZE-1:0] head;
    logic [DSIZE-1:0] skid;
    logic             accept;

    // Pop decision uses only registered state, never m_ready.
    assign rinc      = rrst_n & enable & ~rempty & (state != TWO);
    assign accept    = m.m_valid & m.m_ready;
    assign m.m_valid = (state != EMPTY);
    assign m.m_data  = head;
    assign occupancy = state;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (rinc) begin
                        head  <= rdata;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (rinc && accept) begin
                        head <= rdata;
                    end else if (rinc) begin
                        skid  <= rdata;
                        state <= TWO;
                    end else if (accept) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (accept) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    sat_counter #(.WIDTH(CNT_W)) u_word_cnt (
        .clk   (rclk),
        .rst_n (rrst_n),
        .clr   (clr_stats),
        .inc   (accept),
        .count (word_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (rclk),
        .rst_n (rrst_n),
        .clr   (clr_stats),
        .inc   (m.m_valid & ~m.m_ready),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-based model of the FIFO read port.
module tb_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       rinc;
    logic       enable;
    logic [1:0] occupancy;
`ifdef FIFO_RD_STATS_EN
    logic       clr_stats;
    logic [3:0] word_cnt;
    logic [3:0] stall_cnt;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0]  q[$];
    logic [7:0]  popped;
    logic [7:0]  exp_next;

    fifo_rd_stream_if #(.DSIZE(8)) s ();

`ifdef FIFO_RD_STATS_EN
    fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .enable    (enable),
        .m         (s),
        .occupancy (occupancy),
        .clr_stats (clr_stats),
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    fifo_rd_stream #(.DSIZE(8)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .enable    (enable),
        .m         (s),
        .occupancy (occupancy)
    );
`endif

    always #5 rclk = ~rclk;

    // Fall-through FIFO with registered empty flag.
    always @(posedge rclk) begin
        if (rinc && q.size() > 0) popped = q.pop_front();
        rempty <= (q.size() == 0);
        rdata  <= (q.size() > 0) ? q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge rclk);
    endtask

    initial begin
        rrst_n   = 1'b0;
        enable   = 1'b1;
        s.m_ready = 1'b1;
`ifdef FIFO_RD_STATS_EN
        clr_stats = 1'b0;
`endif
        q.push_back(8'hEE);

        // Reset held with the FIFO reporting non-empty.
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_rinc", rinc, 0);
            check("rst_valid", s.m_valid, 0);
            check("rst_data", s.m_data, 0);
            check("rst_occ", occupancy, 0);
`ifdef FIFO_RD_STATS_EN
            check("rst_word_cnt", word_cnt, 0);
            check("rst_stall_cnt", stall_cnt, 0);
`endif
        end
        enable = 1'b0;
        q.delete();
        rrst_n = 1'b1;
        step();
        check("post_rst_rinc", rinc, 0);
        check("post_rst_valid", s.m_valid, 0);
        enable = 1'b1;

        // Streaming 0x01..0x0A at full rate.
        for (int i = 1; i <= 10; i++) q.push_back(8'(i));
        for (int i = 1; i <= 12; i++) begin
            step();
            check("str_rinc", rinc, (i <= 10) ? 1 : 0);
            check("str_valid", s.m_valid, (i >= 2 && i <= 11) ? 1 : 0);
            check("str_occ", occupancy, (i >= 2 && i <= 11) ? 1 : 0);
            if (i >= 2 && i <= 11) check("str_data", s.m_data, i - 1);
        end

        // Back-pressure: m_ready low for cycles 4..8 of a 0x10..0x1F stream.
        exp_next = 8'h10;
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h10 + i));
        for (int k = 1; k <= 24; k++) begin
            step();
            s.m_ready = !(k >= 4 && k <= 8);
            if (k == 4) begin
                check("bp_occ_pre", occupancy, 1);
                check("bp_rinc_pre", rinc, 1);
            end
            if (k >= 5 && k <= 9) begin
                check("bp_occ_stall", occupancy, 2);
                check("bp_rinc_stall", rinc, 0);
                check("bp_data_hold", s.m_data, 8'h12);
            end
            if (k == 10) check("bp_resume_rinc", rinc, 1);
            if (s.m_valid && s.m_ready) begin
                check("bp_order", s.m_data, exp_next);
                exp_next++;
            end
        end
        check("bp_count", exp_next, 8'h20);
        check("bp_idle_valid", s.m_valid, 0);

        // Enable gating while the buffer is full.
        s.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h30 + i));
        step();
        check("en_c1_rinc", rinc, 1);
        step();
        check("en_c2_occ", occupancy, 1);
        check("en_c2_data", s.m_data, 8'h30);
        step();
        check("en_c3_occ", occupancy, 2);
        check("en_c3_rinc", rinc, 0);
        enable = 1'b0;
        step();
        s.m_ready = 1'b1;
        check("en_c4_occ", occupancy, 2);
        check("en_c4_data", s.m_data, 8'h30);
        step();
        check("en_c5_occ", occupancy, 1);
        check("en_c5_data", s.m_data, 8'h31);
        check("en_c5_rinc", rinc, 0);
        step();
        check("en_c6_valid", s.m_valid, 0);
        check("en_c6_occ", occupancy, 0);
        check("en_c6_rinc", rinc, 0);
        step();
        check("en_c7_rinc", rinc, 0);
        enable = 1'b1;
        #1;
        check("en_reenable_rinc", rinc, 1);
        for (int j = 0; j < 4; j++) begin
            step();
            check("en_drain_valid", s.m_valid, 1);
            check("en_drain_data", s.m_data, 8'h32 + j);
        end
        step();
        check("en_final_valid", s.m_valid, 0);

        // Single-word boundary.
        q.push_back(8'hAB);
        check("one_c0_rinc", rinc, 0);
        step();
        check("one_c1_rinc", rinc, 1);
        check("one_c1_valid", s.m_valid, 0);
        step();
        check("one_c2_rinc", rinc, 0);
        check("one_c2_valid", s.m_valid, 1);
        check("one_c2_data", s.m_data, 8'hAB);
        step();
        check("one_c3_valid", s.m_valid, 0);
        check("one_c3_rinc", rinc, 0);

`ifdef FIFO_RD_STATS_EN
        // Statistics: saturation, stall counting, clear during accept.
        step();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("st_clr_word", word_cnt, 0);
        check("st_clr_stall", stall_cnt, 0);
        for (int i = 0; i < 20; i++) q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 24; i++) step();
        check("st_word_sat", word_cnt, 15);
        check("st_stall_zero", stall_cnt, 0);
        s.m_ready = 1'b0;
        q.push_back(8'h60);
        for (int i = 0; i < 4; i++) step();
        check("st_stall_2", stall_cnt, 2);
        step();
        s.m_ready = 1'b1;
        clr_stats = 1'b1;
        check("st_stall_3", stall_cnt, 3);
        check("st_valid_pre_clr", s.m_valid, 1);
        step();
        clr_stats = 1'b0;
        check("st_clr_acc_word", word_cnt, 0);
        check("st_clr_acc_stall", stall_cnt, 0);
        check("st_clr_acc_valid", s.m_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
